// File: rtl/yblock_cfg_loader.sv
// yblock_cfg_loader
// Feeds a yblock array one config row at a time. It drives cbitin, confclk
// and reset to the block, and it captures the row that falls out of cbitout
// on every strobe, so the old configuration is read back during a new load.
module yblock_cfg_loader #(
    parameter int BLOCKWIDTH  = 8,
    parameter int BLOCKHEIGHT = 8,
    parameter int STROBE_W    = 1,
    parameter int CLR_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clr_first,
    input  logic                  abort,
    input  logic [BLOCKWIDTH-1:0] row_data,
    input  logic                  row_valid,
    output logic                  row_ready,
    output logic [BLOCKWIDTH-1:0] cbitin,
    output logic                  confclk,
    output logic                  blk_reset,
    input  logic [BLOCKWIDTH-1:0] cbitout,
    output logic [BLOCKWIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    // One counter times both the CLEAR phase and the confclk high phase.
    localparam int CNT_MAX = (STROBE_W > CLR_CYCLES) ? STROBE_W : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = $clog2(BLOCKHEIGHT + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_W - 1);
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(BLOCKHEIGHT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic [BLOCKWIDTH-1:0]   cbitin_q, cbitin_d;
    logic [BLOCKWIDTH-1:0]   rb_data_q, rb_data_d;
    logic                    ready_q, ready_d;
    logic                    confclk_q, confclk_d;
    logic                    blk_reset_q, blk_reset_d;
    logic                    rb_valid_q, rb_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    fire;
    logic                    abort_now;

    // Next state, counters and the registered-output values they imply.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_cnt_d = row_cnt_q;

        fire      = (state_q == ST_WAIT) && ready_q && row_valid;
        abort_now = abort && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    row_cnt_d = '0;
                    cnt_d     = '0;
                    state_d   = clr_first ? ST_CLEAR : ST_WAIT;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (fire) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
                state_d   = (row_cnt_q == ROW_LAST) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats everything else; the partial shift stays in the block.
        if (abort_now) begin
            state_d   = ST_IDLE;
            row_cnt_d = '0;
            cnt_d     = '0;
        end

        // WAIT spends one settle cycle before offering row_ready; the last
        // CLEAR cycle doubles as that settle cycle.
        ready_d     = (state_d == ST_WAIT) &&
                      (((state_q == ST_WAIT) && !fire) || (state_q == ST_CLEAR));
        confclk_d   = (state_d == ST_STROBE);
        blk_reset_d = (state_d == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        rb_valid_d  = (state_q == ST_SETUP) && (state_d == ST_STROBE);
        aborted_d   = abort_now;

        cbitin_d  = ((state_q == ST_WAIT) && (state_d == ST_SETUP)) ? row_data : cbitin_q;
        // cbitout is sampled on the edge that raises confclk, i.e. pre-shift.
        rb_data_d = rb_valid_d ? cbitout : rb_data_q;
    end

    // State and output registers; reset drives the block into reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            row_cnt_q   <= '0;
            cbitin_q    <= '0;
            rb_data_q   <= '0;
            ready_q     <= 1'b0;
            confclk_q   <= 1'b0;
            blk_reset_q <= 1'b1;
            rb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_cnt_q   <= row_cnt_d;
            cbitin_q    <= cbitin_d;
            rb_data_q   <= rb_data_d;
            ready_q     <= ready_d;
            confclk_q   <= confclk_d;
            blk_reset_q <= blk_reset_d;
            rb_valid_q  <= rb_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign row_ready = ready_q;
    assign cbitin    = cbitin_q;
    assign confclk   = confclk_q;
    assign blk_reset = blk_reset_q;
    assign rb_data   = rb_data_q;
    assign rb_valid  = rb_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Bench for yblock_cfg_loader with a behavioural 8x8 yblock shift column
// model hanging off cbitin/confclk/blk_reset/cbitout.
module tb_yblock_cfg_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       clr_first = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] row_data = 8'h00;
    logic       row_valid = 1'b0;
    logic       row_ready;
    logic [7:0] cbitin;
    logic       confclk;
    logic       blk_reset;
    logic [7:0] cbitout;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic       busy;
    logic       done;
    logic       aborted;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int rb_seen  = 0;
    logic       stop_rows = 1'b0;
    logic [7:0] cur_row = 8'h00;
    logic [7:0] mon_exp;

    logic [7:0] exp_rb_q[$];   // expected readback per accepted row
    logic [7:0] blk_q[$];      // reference block content, bottom row at front

    logic [7:0] blk_mem [8] = '{default: 8'h00};

    yblock_cfg_loader #(
        .BLOCKWIDTH (8),
        .BLOCKHEIGHT(8),
        .STROBE_W   (1),
        .CLR_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .clr_first(clr_first),
        .abort    (abort),
        .row_data (row_data),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .cbitin   (cbitin),
        .confclk  (confclk),
        .blk_reset(blk_reset),
        .cbitout  (cbitout),
        .rb_data  (rb_data),
        .rb_valid (rb_valid),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    // yblock column model: shifts down on confclk, cleared by its reset.
    always @(posedge confclk or posedge blk_reset) begin
        if (blk_reset) begin
            for (int i = 0; i < 8; i++) blk_mem[i] <= 8'h00;
        end else begin
            for (int i = 7; i > 0; i--) blk_mem[i] <= blk_mem[i-1];
            blk_mem[0] <= cbitin;
        end
    end
    assign cbitout = blk_mem[7];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Readback scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rb_valid) begin
            rb_seen++;
            if (exp_rb_q.size() == 0) begin
                chk_eq("rb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_rb_q.pop_front();
                $display("RB   data=%02h exp=%02h", rb_data, mon_exp);
                chk_eq("rb_data", rb_data, mon_exp);
            end
        end
        if (done) chk_eq("done_with_rb_valid", rb_valid, 0);
        if (row_ready) chk_eq("confclk_in_wait", confclk, 0);
    end

    always @(posedge confclk) begin
        strobes++;
        chk_eq("cbitin_at_rise", cbitin, cur_row);
    end

    task automatic reset_blk_ref();
        blk_q.delete();
        for (int i = 0; i < 8; i++) blk_q.push_back(8'h00);
    endtask

    task automatic send_rows(input int n, input logic [7:0] base, input int gap, output int sent);
        int cyc;
        sent = 0;
        cyc  = 0;
        row_data  = base;
        row_valid = 1'b1;
        while (sent < n && !stop_rows && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (row_valid && row_ready) begin
                exp_rb_q.push_back(blk_q.pop_front());
                blk_q.push_back(row_data);
                cur_row = row_data;
                sent++;
                @(posedge clk);
                #1;
                row_data = base + 8'(sent);
                if (gap > 0 && sent < n) begin
                    row_valid = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                    row_valid = 1'b1;
                end
            end
        end
        row_valid = 1'b0;
    endtask

    task automatic start_load(input logic clr);
        start     = 1'b1;
        clr_first = clr;
        @(posedge clk);
        #1;
        start     = 1'b0;
        clr_first = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (done || n >= 400) break;
            n++;
        end
        if (!done) chk_eq("done_seen", 32'd0, 32'd1);
    endtask

    task automatic run_load(input logic clr, input logic [7:0] base, input int gap,
                            input int exp_lat, input string tag);
        int sent, lat, s0, r0;
        s0 = strobes;
        r0 = rb_seen;
        lat = 0;
        if (clr) reset_blk_ref();
        fork
            send_rows(8, base, gap, sent);
            begin
                start_load(clr);
                if (clr) begin
                    @(negedge clk);
                    chk_eq("clr_c1_blk_reset", blk_reset, 1);
                    chk_eq("clr_c1_ready", row_ready, 0);
                    @(negedge clk);
                    chk_eq("clr_c2_blk_reset", blk_reset, 1);
                    chk_eq("clr_c2_ready", row_ready, 0);
                    @(negedge clk);
                    chk_eq("clr_c3_blk_reset", blk_reset, 0);
                    chk_eq("clr_c3_ready", row_ready, 1);
                end
                wait_done(lat);
            end
        join
        if (exp_lat > 0) chk_eq("done_latency", lat, exp_lat);
        @(negedge clk);
        chk_eq("busy_after_done", busy, 0);
        chk_eq("done_one_cycle", done, 0);
        chk_eq("strobe_count", strobes - s0, 8);
        chk_eq("rb_valid_count", rb_seen - r0, 8);
        chk_eq("rows_consumed", sent, 8);
        chk_eq("scoreboard_empty", exp_rb_q.size(), 0);
        $display("LOAD %s rows=%0d latency=%0d", tag, sent, lat);
    endtask

    initial begin
        int sent, n, s0;
        reset_blk_ref();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_blk_reset", blk_reset, 1);
        chk_eq("rst_confclk", confclk, 0);
        chk_eq("rst_cbitin", cbitin, 0);
        chk_eq("rst_rb_data", rb_data, 0);
        chk_eq("rst_row_ready", row_ready, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_aborted", aborted, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("blk_reset_release", blk_reset, 0);

        // Plain loads: first from an empty block, then a reload reading it back
        run_load(1'b0, 8'h01, 0, 41, "first");
        run_load(1'b0, 8'hA0, 0, 41, "reload");

        // Clear first, rows arriving with gaps
        run_load(1'b1, 8'h10, 5, 0, "clear_gaps");

        // Abort during the second strobe
        s0 = strobes;
        fork
            send_rows(8, 8'h30, 0, sent);
            begin
                start_load(1'b0);
                n = 0;
                while (strobes < s0 + 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk_eq("abort_in_strobe", confclk, 1);
                abort = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                @(negedge clk);
                chk_eq("abort_confclk", confclk, 0);
                chk_eq("abort_pulse", aborted, 1);
                chk_eq("abort_done", done, 0);
                chk_eq("abort_busy", busy, 0);
                stop_rows = 1'b1;
                @(negedge clk);
                chk_eq("abort_one_cycle", aborted, 0);
            end
        join
        stop_rows = 1'b0;
        chk_eq("abort_rows_taken", sent, 2);
        $display("ABORT rows_taken=%0d", sent);
        run_load(1'b0, 8'h40, 0, 41, "after_abort");

        // Asynchronous reset in the middle of a load
        fork
            send_rows(8, 8'h50, 0, sent);
            begin
                start_load(1'b0);
                repeat (12) @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                chk_eq("arst_blk_reset", blk_reset, 1);
                chk_eq("arst_confclk", confclk, 0);
                chk_eq("arst_busy", busy, 0);
                chk_eq("arst_row_ready", row_ready, 0);
                chk_eq("arst_cbitin", cbitin, 0);
                chk_eq("arst_rb_data", rb_data, 0);
                stop_rows = 1'b1;
                @(posedge clk);
                #4;
                reset_n = 1'b1;
            end
        join
        stop_rows = 1'b0;
        exp_rb_q.delete();
        reset_blk_ref();
        $display("ARST rows_taken_before_reset=%0d", sent);
        row_data  = 8'h77;
        row_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_eq("arst_no_consume", row_ready, 0);
        end
        row_valid = 1'b0;
        run_load(1'b0, 8'h60, 0, 41, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
